// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline-register fields in, stall/flush controls out.
// The pipeline side uses the master modport, the controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       idRs1;
    logic [4:0]       idRs2;
    logic             idUseRs1;
    logic             idUseRs2;
    logic [4:0]       exRd;
    logic             exMemRead;
    logic             branchTaken;
    logic             memBusy;
    logic             clrCount;
    logic             selOp;
    logic             pcWrite;
    logic             ifIdWrite;
    logic             ifIdFlush;
    logic             pipeFreeze;
    logic [CNT_W-1:0] bubbleCount;

    modport master (
        output idRs1, idRs2, idUseRs1, idUseRs2, exRd, exMemRead,
               branchTaken, memBusy, clrCount,
        input  selOp, pcWrite, ifIdWrite, ifIdFlush, pipeFreeze, bubbleCount
    );

    modport slave (
        input  idRs1, idRs2, idUseRs1, idUseRs2, exRd, exMemRead,
               branchTaken, memBusy, clrCount,
        output selOp, pcWrite, ifIdWrite, ifIdFlush, pipeFreeze, bubbleCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / control hazard controller: bubble select, PC and IF/ID enables, flush,
// freeze, a load-latency stretch FSM and a saturating bubble-cycle counter.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, STALL} state_t;

    localparam logic [3:0] STALL_INIT = 4'(LOAD_LAT - 1);

    state_t           state, state_nxt;
    logic [3:0]       remain, remain_nxt;
    logic [CNT_W-1:0] count;
    logic             lu_haz;
    logic             sel_op, pc_write, if_id_write, if_id_flush, pipe_freeze;

    assign lu_haz = hz.exMemRead && (hz.exRd != 5'd0) &&
                    ((hz.idUseRs1 && (hz.exRd == hz.idRs1)) ||
                     (hz.idUseRs2 && (hz.exRd == hz.idRs2)));

    // NOTE: every output and next-state term gets a default first, so no path infers a latch.
    always_comb begin
        sel_op      = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        remain_nxt  = remain;

        if (!rst_n) begin
            // Outputs are driven to a flushing bubble for the whole reset interval.
            sel_op      = 1'b1;
            if_id_flush = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (hz.memBusy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (hz.branchTaken) begin
            // The stalled instruction is wrong-path, so any stretch is abandoned.
            sel_op      = 1'b1;
            if_id_flush = 1'b1;
            state_nxt   = RUN;
            remain_nxt  = 4'd0;
        end else if (state == STALL) begin
            sel_op      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            remain_nxt  = remain - 4'd1;
            if (remain == 4'd1) state_nxt = RUN;
        end else if (lu_haz) begin
            sel_op      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if (LOAD_LAT > 1) begin
                state_nxt  = STALL;
                remain_nxt = STALL_INIT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            remain <= 4'd0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    // selOp is already 0 during memBusy, so a frozen cycle never counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (hz.clrCount) begin
            count <= '0;
        end else if (sel_op && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hz.selOp       = sel_op;
    assign hz.pcWrite     = pc_write;
    assign hz.ifIdWrite   = if_id_write;
    assign hz.ifIdFlush   = if_id_flush;
    assign hz.pipeFreeze  = pipe_freeze;
    assign hz.bubbleCount = count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4)
// share one stimulus; a negedge monitor pops expected entries and compares.
module tb_hazard_ctrl;
    // Flag vector order: {selOp, pcWrite, ifIdWrite, ifIdFlush, pipeFreeze}
    localparam logic [4:0] F_RUN = 5'b01100;
    localparam logic [4:0] F_BUB = 5'b10000;
    localparam logic [4:0] F_BR  = 5'b11110;
    localparam logic [4:0] F_FRZ = 5'b00001;
    localparam logic [4:0] F_RST = 5'b10010;

    typedef struct {
        int         dut;
        string      name;
        logic [4:0] flags;
        int         cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, mem_busy, clr_count;

    int   errors = 0;
    int   total  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) if_a ();
    hazard_ctrl_if #(.CNT_W(16)) if_b ();
    hazard_ctrl_if #(.CNT_W(4))  if_c ();

    assign if_a.idRs1 = id_rs1;  assign if_a.idRs2 = id_rs2;  assign if_a.idUseRs1 = id_use_rs1;
    assign if_a.idUseRs2 = id_use_rs2;  assign if_a.exRd = ex_rd;  assign if_a.exMemRead = ex_mem_read;
    assign if_a.branchTaken = branch_taken;  assign if_a.memBusy = mem_busy;  assign if_a.clrCount = clr_count;
    assign if_b.idRs1 = id_rs1;  assign if_b.idRs2 = id_rs2;  assign if_b.idUseRs1 = id_use_rs1;
    assign if_b.idUseRs2 = id_use_rs2;  assign if_b.exRd = ex_rd;  assign if_b.exMemRead = ex_mem_read;
    assign if_b.branchTaken = branch_taken;  assign if_b.memBusy = mem_busy;  assign if_b.clrCount = clr_count;
    assign if_c.idRs1 = id_rs1;  assign if_c.idRs2 = id_rs2;  assign if_c.idUseRs1 = id_use_rs1;
    assign if_c.idUseRs2 = id_use_rs2;  assign if_c.exRd = ex_rd;  assign if_c.exMemRead = ex_mem_read;
    assign if_c.branchTaken = branch_taken;  assign if_c.memBusy = mem_busy;  assign if_c.clrCount = clr_count;

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_lat1 (.clk(clk), .rst_n(rst_n), .hz(if_a));
    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_lat3 (.clk(clk), .rst_n(rst_n), .hz(if_b));
    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4))  u_sat  (.clk(clk), .rst_n(rst_n), .hz(if_c));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [4:0]  act_f;
            logic [31:0] act_c;
            e = sb.pop_front();
            case (e.dut)
                0: begin
                    act_f = {if_a.selOp, if_a.pcWrite, if_a.ifIdWrite, if_a.ifIdFlush, if_a.pipeFreeze};
                    act_c = 32'(if_a.bubbleCount);
                end
                1: begin
                    act_f = {if_b.selOp, if_b.pcWrite, if_b.ifIdWrite, if_b.ifIdFlush, if_b.pipeFreeze};
                    act_c = 32'(if_b.bubbleCount);
                end
                default: begin
                    act_f = {if_c.selOp, if_c.pcWrite, if_c.ifIdWrite, if_c.ifIdFlush, if_c.pipeFreeze};
                    act_c = 32'(if_c.bubbleCount);
                end
            endcase
            check({e.name, " flags"}, 32'(act_f), 32'(e.flags));
            check({e.name, " count"}, act_c, e.cnt);
        end
    end

    task automatic drive(logic mr, logic [4:0] rd, logic [4:0] r1, logic u1,
                         logic [4:0] r2, logic u2, logic br, logic busy, logic clr);
        ex_mem_read = mr;  ex_rd = rd;  id_rs1 = r1;  id_use_rs1 = u1;
        id_rs2 = r2;  id_use_rs2 = u2;  branch_taken = br;  mem_busy = busy;  clr_count = clr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue this cycle's expectation, then advance to just after the next rising edge.
    task automatic cyc(int dut, string name, logic [4:0] f, int cnt);
        sb.push_back('{dut, name, f, cnt});
        @(posedge clk);
        #1;
    endtask

    // Reset is dropped mid-cycle, so the checks see its effect before any clock edge.
    task automatic do_reset(string name);
        rst_n = 1'b0;
        idle();
        sb.push_back('{0, {name, " a"}, F_RST, 0});
        sb.push_back('{1, {name, " b"}, F_RST, 0});
        cyc(2, {name, " c"}, F_RST, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;

        // LOAD_LAT=1: single bubble
        do_reset("rst1");
        cyc(0, "t1 idle", F_RUN, 0);
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, "t1 haz", F_BUB, 0);
        idle();
        cyc(0, "t1 after", F_RUN, 1);
        cyc(0, "t1 after2", F_RUN, 1);

        // LOAD_LAT=3: three bubbles from a one-cycle hazard
        do_reset("rst2");
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, "t2 b0", F_BUB, 0);
        idle();
        cyc(1, "t2 b1", F_BUB, 1);
        cyc(1, "t2 b2", F_BUB, 2);
        cyc(1, "t2 run", F_RUN, 3);
        cyc(1, "t2 run2", F_RUN, 3);

        // LOAD_LAT=3: memBusy during the second bubble stretches without consuming
        do_reset("rst3");
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, "t3 b0", F_BUB, 0);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1, "t3 frz0", F_FRZ, 1);
        cyc(1, "t3 frz1", F_FRZ, 1);
        idle();
        cyc(1, "t3 b1", F_BUB, 1);
        cyc(1, "t3 b2", F_BUB, 2);
        cyc(1, "t3 run", F_RUN, 3);

        // Branch with concurrent luHaz, then luHaz held; then branch aborting a STALL
        do_reset("rst4");
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1, "t4 br+haz", F_BR, 0);
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, "t4 haz", F_BUB, 1);
        idle();
        cyc(1, "t4 s1", F_BUB, 2);
        cyc(1, "t4 s2", F_BUB, 3);
        cyc(1, "t4 run", F_RUN, 4);
        drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1, "t4 haz2", F_BUB, 4);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1, "t4 abort", F_BR, 5);
        idle();
        cyc(1, "t4 run2", F_RUN, 6);

        // Non-hazards: exRd=0, rs2 unused, not a load; then a real rs2 hazard
        do_reset("rst5");
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, "t5 rd0", F_RUN, 0);
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, "t5 rs2 unused", F_RUN, 0);
        drive(1'b0, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1, "t5 not load", F_RUN, 0);
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1, "t5 rs2 hit", F_BUB, 0);
        idle();
        cyc(1, "t5 s1", F_BUB, 1);
        cyc(1, "t5 s2", F_BUB, 2);
        cyc(1, "t5 run", F_RUN, 3);

        // CNT_W=4: saturation, clear priority, reset mid-STALL
        do_reset("rst6");
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(2, $sformatf("t6 br%0d", i), F_BR, (i > 15) ? 15 : i);
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(2, "t6 clr+bub", F_BR, 15);
        idle();
        cyc(2, "t6 cleared", F_RUN, 0);
        drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(2, "t6 haz", F_BUB, 0);
        idle();
        cyc(2, "t6 s1", F_BUB, 1);
        do_reset("t6 rst stall");
        cyc(2, "t6 post rst", F_RUN, 0);
        cyc(2, "t6 post rst2", F_RUN, 0);

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RISC-V core. Detects load-use and control hazards from the ID and EX pipeline-register fields, and generates the bubble-select `selOp` consumed by the control-signal mux. It also generates the PC / IF-ID write enables, the IF-ID flush and the global freeze. A small FSM stretches load-use bubbles to a configurable load latency, and a saturating counter records bubble cycles for performance analysis.

## Interface
Parameters:
- `LOAD_LAT`, default 1: bubble cycles inserted per load-use hazard; legal range 1..15.
- `CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `idRs1`, `idRs2` in 5 each: source registers of the instruction in ID.
- `idUseRs1`, `idUseRs2` in 1 each: the ID instruction actually reads rs1 / rs2.
- `exRd` in 5: destination register of the instruction in EX.
- `exMemRead` in 1: the EX instruction is a load.
- `branchTaken` in 1: EX resolved a taken branch or jump this cycle.
- `memBusy` in 1: data memory is not ready; the whole pipeline must freeze.
- `clrCount` in 1: synchronous clear of `bubbleCount`.
- `selOp` out 1: 1 = control mux forces ID/EX controls to zero (bubble).
- `pcWrite` out 1: PC register enable.
- `ifIdWrite` out 1: IF/ID register enable.
- `ifIdFlush` out 1: IF/ID register loads a NOP.
- `pipeFreeze` out 1: ID/EX, EX/MEM and MEM/WB hold their contents.
- `bubbleCount` out CNT_W: saturating count of bubble cycles.

## Operation
- FSM states:
  - RUN (reset state).
  - STALL: extends a load-use bubble; holds a 4-bit `remain` counter.
- Load-use hazard, evaluated combinationally: `luHaz` = exMemRead & (exRd != 0) & ((idUseRs1 & exRd == idRs1) | (idUseRs2 & exRd == idRs2)).
- Output priority, highest first:
  1. `memBusy`: pipeFreeze=1, pcWrite=0, ifIdWrite=0, selOp=0, ifIdFlush=0. State, `remain` and `bubbleCount` hold.
  2. `branchTaken`: selOp=1, ifIdFlush=1, pcWrite=1, ifIdWrite=1. The next state is RUN (aborts any STALL, since the stalled instruction is wrong-path).
  3. STALL state: selOp=1, pcWrite=0, ifIdWrite=0. `remain` decrements each cycle; when `remain` is 1, the next state is RUN.
  4. RUN with `luHaz`: selOp=1, pcWrite=0, ifIdWrite=0. If LOAD_LAT > 1, the next state is STALL with remain = LOAD_LAT-1; otherwise the FSM stays in RUN.
  5. Otherwise: pcWrite=1, ifIdWrite=1, all other outputs 0.
- `bubbleCount`:
  - Increments on every clock edge at which selOp=1.
  - Saturates at 2^CNT_W-1.
  - `clrCount` forces it to 0 and takes priority over the increment.
- While `rst_n` = 0, outputs are forced to: selOp=1, ifIdFlush=1, pcWrite=0, ifIdWrite=0, pipeFreeze=0. `bubbleCount` is 0.

## Timing
- All outputs except `bubbleCount` are combinational from the current state and inputs, so they take effect in the same cycle as the hazard. No registered latency.
- A load-use hazard produces exactly LOAD_LAT consecutive selOp=1 cycles, not counting frozen cycles. `memBusy` cycles stretch the sequence without consuming `remain`.
- `bubbleCount` updates at the edge ending each bubble cycle, so it is visible the following cycle.
- Asynchronous reset assertion mid-STALL:
  - State goes to RUN, `remain` to 0, `bubbleCount` to 0 immediately, without waiting for a clock edge.
  - After deassertion, the first edge behaves as RUN.
- Simultaneous `luHaz` and `branchTaken`: branch wins, no STALL entry, one bubble counted.
- exRd = 0 never causes a stall, even when exMemRead=1.

## Test plan
- LOAD_LAT=1: exMemRead=1, exRd=5, idRs1=5, idUseRs1=1 for one cycle. Expect selOp=1, pcWrite=0, ifIdWrite=0 in that cycle only; bubbleCount goes 0→1.
- LOAD_LAT=3: the same hazard, held for one cycle. Expect 3 consecutive bubble cycles (RUN, STALL remain=2, STALL remain=1), then RUN; bubbleCount=3.
- LOAD_LAT=3: memBusy=1 for 2 cycles starting in the second bubble cycle. Expect pipeFreeze=1 and selOp=0 for 2 cycles, then 2 more bubble cycles; total bubbleCount=3.
- branchTaken=1 concurrent with luHaz, then luHaz held. Expect ifIdFlush=1 and selOp=1 in cycle 0; the next cycle evaluates luHaz fresh from RUN.
- exRd=0, exMemRead=1, idRs1=0, idUseRs1=1. Expect no stall, pcWrite=1. Also exRd=7 matching idRs2 with idUseRs2=0: no stall.
- CNT_W=4: force 20 bubble cycles and expect bubbleCount saturated at 15; then assert clrCount with a simultaneous bubble and expect 0. Finally drop rst_n in STALL and expect RUN outputs immediately after release.
